// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with standard or first-word-fall-through read,
// count-derived status flags and sticky overflow/underflow indicators.
module param_sync_fifo #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Accept decisions use the pre-edge flags; clear overrides both requests.
  always_comb begin
    w_wr_acc = wr_en & ~full  & ~clear;
    w_rd_acc = rd_en & ~empty & ~clear;
  end

  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Pointers and occupancy; power-of-two depth makes wrap a natural rollover.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags, cleared only by clear or reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && full)  r_overflow  <= 1'b1;
      if (rd_en && empty) r_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  if (FWFT == 0) begin : g_std
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    // Registered read: data captured on the accepting edge, valid for one cycle.
    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else if (clear) begin
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
      end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
  end else begin : g_fwft
    // Head word is presented directly; forced to zero while nothing is stored.
    assign rd_data  = empty ? '0 : r_mem[r_rd_ptr];
    assign rd_valid = ~empty;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: a standard-read and a FWFT instance share stimulus and are
// compared against a queue-based reference model, a vector table and corner sequences.
module tb_param_sync_fifo;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic         clear = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] wr_data = '0;

  logic [W-1:0]  o_rdd  [2];
  logic          o_rv   [2];
  logic          o_full [2];
  logic          o_empty[2];
  logic          o_af   [2];
  logic          o_ae   [2];
  logic [CW-1:0] o_cnt  [2];
  logic          o_ovf  [2];
  logic          o_unf  [2];

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .rst_(rst_), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(o_rdd[0]), .rd_valid(o_rv[0]), .full(o_full[0]),
    .empty(o_empty[0]), .almost_full(o_af[0]), .almost_empty(o_ae[0]),
    .count(o_cnt[0]), .overflow(o_ovf[0]), .underflow(o_unf[0]));

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .rst_(rst_), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(o_rdd[1]), .rd_valid(o_rv[1]), .full(o_full[1]),
    .empty(o_empty[1]), .almost_full(o_af[1]), .almost_empty(o_ae[1]),
    .count(o_cnt[1]), .overflow(o_ovf[1]), .underflow(o_unf[1]));

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf, m_rv, m_rdd_known;
  logic [W-1:0] m_rdd;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit           w, r, c;
    logic [W-1:0] d;
    int           cnt;
    bit           emp, unf, rv, chk_rdd;
    logic [W-1:0] rdd;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count[%0d]", i), 32'(o_cnt[i]), 32'(n));
      chk($sformatf("full[%0d]", i),  32'(o_full[i]),  32'(n == D));
      chk($sformatf("empty[%0d]", i), 32'(o_empty[i]), 32'(n == 0));
      chk($sformatf("afull[%0d]", i), 32'(o_af[i]),    32'(n >= D - 2));
      chk($sformatf("aempty[%0d]", i), 32'(o_ae[i]),   32'(n <= 2));
      chk($sformatf("ovf[%0d]", i),   32'(o_ovf[i]),   32'(m_ovf));
      chk($sformatf("unf[%0d]", i),   32'(o_unf[i]),   32'(m_unf));
    end
    chk("rv_std", 32'(o_rv[0]), 32'(m_rv));
    if (m_rdd_known) chk("rdd_std", 32'(o_rdd[0]), 32'(m_rdd));
    chk("rv_fwft", 32'(o_rv[1]), 32'(n > 0));
    if (n > 0) chk("rdd_fwft", 32'(o_rdd[1]), 32'(q[0]));
  endtask

  task automatic model_edge(input bit w, input bit r, input bit c, input logic [W-1:0] d);
    int n = q.size();
    if (c) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rdd_known = 0;
    end else begin
      if (w && n == D) m_ovf = 1;
      if (r && n == 0) m_unf = 1;
      if (r && n > 0) begin
        m_rdd = q.pop_front();
        m_rv = 1;
        m_rdd_known = 1;
      end else begin
        m_rv = 0;
      end
      if (w && n < D) q.push_back(d);
    end
  endtask

  task automatic step(input bit w, input bit r, input bit c, input logic [W-1:0] d);
    wr_en = w; rd_en = r; clear = c; wr_data = d;
    @(posedge clk);
    model_edge(w, r, c, d);
    #1;
    check_all();
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  // Asynchronous reset: outputs are checked 1 time unit after assertion, no edge needed.
  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    rst_ = 1'b0;
    #1;
    q.delete();
    m_ovf = 0; m_unf = 0; m_rv = 0; m_rdd = '0; m_rdd_known = 1;
    check_all();
    chk("rst_rdd_fwft", 32'(o_rdd[1]), 32'h0);
    chk("rst_ae", 32'(o_ae[0]), 32'h1);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  initial begin
    logic [W-1:0] dat;
    bit w, r, c;

    tbl[0]  = '{0, 1, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h0000};
    tbl[1]  = '{1, 0, 0, 16'h0A01, 1, 0, 1, 0, 1, 16'h0000};
    tbl[2]  = '{1, 0, 0, 16'h0A02, 2, 0, 1, 0, 1, 16'h0000};
    tbl[3]  = '{1, 1, 0, 16'h0A03, 2, 0, 1, 1, 1, 16'h0A01};
    tbl[4]  = '{0, 1, 0, 16'h0000, 1, 0, 1, 1, 1, 16'h0A02};
    tbl[5]  = '{0, 0, 0, 16'h0000, 1, 0, 1, 0, 1, 16'h0A02};
    tbl[6]  = '{0, 1, 0, 16'h0000, 0, 1, 1, 1, 1, 16'h0A03};
    tbl[7]  = '{1, 1, 0, 16'h0A04, 1, 0, 1, 0, 1, 16'h0A03};
    tbl[8]  = '{1, 0, 1, 16'h0A05, 0, 1, 0, 0, 0, 16'h0000};
    tbl[9]  = '{1, 0, 0, 16'h0A06, 1, 0, 0, 0, 0, 16'h0000};
    tbl[10] = '{0, 1, 0, 16'h0000, 0, 1, 0, 1, 1, 16'h0A06};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d_cnt", i), 32'(o_cnt[0]),   32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_emp", i), 32'(o_empty[0]), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_unf", i), 32'(o_unf[0]),   32'(tbl[i].unf));
      chk($sformatf("tbl%0d_rv", i),  32'(o_rv[0]),    32'(tbl[i].rv));
      if (tbl[i].chk_rdd) chk($sformatf("tbl%0d_rdd", i), 32'(o_rdd[0]), 32'(tbl[i].rdd));
    end

    // Fill to full, overflow, full+read collision, drain, underflow, empty+write collision
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, W'(i));
      if (i == 13) chk("af_at_13", 32'(o_af[0]), 32'h0);
      if (i == 14) chk("af_at_14", 32'(o_af[0]), 32'h1);
      if (i == 15) chk("full_at_15", 32'(o_full[0]), 32'h0);
    end
    chk("full_at_16", 32'(o_full[0]), 32'h1);
    step(1, 0, 0, 16'h0011);
    chk("ovf_17th", 32'(o_ovf[0]), 32'h1);
    chk("cnt_17th", 32'(o_cnt[0]), 32'd16);
    step(1, 1, 0, 16'h0099);
    chk("full_rw_cnt", 32'(o_cnt[0]), 32'd15);
    chk("full_rw_rdd", 32'(o_rdd[0]), 32'h0001);
    for (int i = 2; i <= 16; i++) begin
      step(0, 1, 0, '0);
      chk($sformatf("drain_rdd%0d", i), 32'(o_rdd[0]), 32'(i));
      chk($sformatf("drain_rv%0d", i), 32'(o_rv[0]), 32'h1);
      step(0, 0, 0, '0);
      chk($sformatf("drain_rv_drop%0d", i), 32'(o_rv[0]), 32'h0);
    end
    chk("drained_empty", 32'(o_empty[0]), 32'h1);
    step(0, 1, 0, '0);
    chk("unf_set", 32'(o_unf[0]), 32'h1);
    step(1, 1, 0, 16'h0055);
    chk("empty_rw_cnt", 32'(o_cnt[0]), 32'd1);
    chk("empty_rw_rv", 32'(o_rv[0]), 32'h0);

    // Count 5 with overflow set, then clear with a concurrent write
    for (int i = 0; i < 15; i++) step(1, 0, 0, W'(16'h0100 + i));
    step(1, 0, 0, 16'h01FF);
    for (int i = 0; i < 11; i++) step(0, 1, 0, '0);
    chk("pre_clr_cnt", 32'(o_cnt[0]), 32'd5);
    chk("pre_clr_ovf", 32'(o_ovf[0]), 32'h1);
    step(1, 0, 1, 16'h0777);
    chk("clr_cnt", 32'(o_cnt[0]), 32'd0);
    chk("clr_empty", 32'(o_empty[0]), 32'h1);
    chk("clr_ovf", 32'(o_ovf[0]), 32'h0);

    // Steady state at count 8 across several pointer wraps
    for (int i = 0; i < 8; i++) step(1, 0, 0, W'(16'h0200 + i));
    for (int i = 0; i < 40; i++) step(1, 1, 0, W'(16'h0300 + i));
    chk("steady_cnt", 32'(o_cnt[0]), 32'd8);
    for (int i = 0; i < 8; i++) step(0, 1, 0, '0);
    chk("steady_last", 32'(o_rdd[0]), 32'h0327);

    // FWFT: word written into empty FIFO is visible before any read
    do_reset();
    step(1, 0, 0, 16'hABCD);
    chk("fwft_rdd", 32'(o_rdd[1]), 32'hABCD);
    chk("fwft_rv", 32'(o_rv[1]), 32'h1);
    step(0, 1, 0, '0);
    chk("fwft_pop_empty", 32'(o_empty[1]), 32'h1);
    chk("fwft_pop_rv", 32'(o_rv[1]), 32'h0);

    // Reset asserted between edges during a burst
    for (int i = 0; i < 6; i++) step(1, (i > 2), 0, W'(16'h0400 + i));
    #2;
    do_reset();
    chk("rst_mid_cnt", 32'(o_cnt[1]), 32'd0);
    step(1, 0, 0, 16'h1234);
    chk("post_rst_cnt", 32'(o_cnt[0]), 32'd1);
    chk("post_rst_fwft", 32'(o_rdd[1]), 32'h1234);

    // Randomised traffic alternating between fill-biased and drain-biased phases
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp  = ((i / 60) % 2 == 0) ? 75 : 25;
      w   = ($urandom_range(0, 99) < wp);
      r   = ($urandom_range(0, 99) < (100 - wp));
      c   = ($urandom_range(0, 79) == 0);
      dat = W'($urandom);
      step(w, r, c, dat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
